// File: rtl/cpu_boot_ctrl.sv
// cpu_boot_ctrl: boot sequencer for a small CPU subsystem.
// Streams ROM_DEPTH words into the ROM write port and RAM_DEPTH words into
// the RAM write port, then runs the CPU until it halts or RUN_CYCLES elapse.
// Optional feature macro: BOOT_CHECKSUM_EN. When defined, the block keeps a
// modular sum of all loaded words and checks it against one extra word
// before letting the CPU run.
module cpu_boot_ctrl #(
  parameter int ROM_W      = 32,
  parameter int RAM_W      = 16,
  parameter int ROM_DEPTH  = 8,
  parameter int RAM_DEPTH  = 16,
  parameter int RUN_CYCLES = 30,
  parameter int CNT_W      = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [ROM_W-1:0]             load_data,
  output logic                         rom_we,
  output logic [$clog2(ROM_DEPTH)-1:0] rom_addr,
  output logic [ROM_W-1:0]             rom_wdata,
  output logic                         ram_we,
  output logic [$clog2(RAM_DEPTH)-1:0] ram_addr,
  output logic [RAM_W-1:0]             ram_wdata,
  output logic                         cpu_run,
  input  logic                         cpu_halt,
  output logic [CNT_W-1:0]             cycle_count,
  output logic                         done,
  output logic                         timeout,
  output logic                         error
);

  localparam int ROM_AW = $clog2(ROM_DEPTH);
  localparam int RAM_AW = $clog2(RAM_DEPTH);

  localparam logic [ROM_AW-1:0] ROM_LAST  = ROM_AW'(ROM_DEPTH - 1);
  localparam logic [RAM_AW-1:0] RAM_LAST  = RAM_AW'(RAM_DEPTH - 1);
  localparam logic [CNT_W-1:0]  RUN_LIMIT = CNT_W'(RUN_CYCLES);

`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_ROM = 3'd1,
    S_LOAD_RAM = 3'd2,
    S_CHECK    = 3'd3,
    S_RUN      = 3'd4,
    S_DONE     = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_ROM = 3'd1,
    S_LOAD_RAM = 3'd2,
    S_RUN      = 3'd4,
    S_DONE     = 3'd5
  } state_t;
`endif

  state_t state_reg, state_next;

  logic [ROM_AW-1:0] rom_idx_reg, rom_idx_next;
  logic [RAM_AW-1:0] ram_idx_reg, ram_idx_next;

  // Write ports are registered so each accepted word appears one cycle later
  // and a reset clears any pending strobe immediately.
  logic              rom_we_reg, rom_we_next;
  logic [ROM_AW-1:0] rom_addr_reg, rom_addr_next;
  logic [ROM_W-1:0]  rom_wdata_reg, rom_wdata_next;
  logic              ram_we_reg, ram_we_next;
  logic [RAM_AW-1:0] ram_addr_reg, ram_addr_next;
  logic [RAM_W-1:0]  ram_wdata_reg, ram_wdata_next;

  logic [CNT_W-1:0]  cycle_count_reg, cycle_count_next;
  logic [CNT_W-1:0]  cycle_count_inc;
  logic              timeout_reg, timeout_next;

`ifdef BOOT_CHECKSUM_EN
  logic [ROM_W-1:0]  sum_reg, sum_next;
  logic              error_reg, error_next;
`endif

  // Saturating increment: the run counter never wraps back to zero.
  assign cycle_count_inc = (cycle_count_reg == {CNT_W{1'b1}}) ? cycle_count_reg
                                                              : cycle_count_reg + 1'b1;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath registers: index counters, write ports and run status.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rom_idx_reg     <= '0;
      ram_idx_reg     <= '0;
      rom_we_reg      <= 1'b0;
      rom_addr_reg    <= '0;
      rom_wdata_reg   <= '0;
      ram_we_reg      <= 1'b0;
      ram_addr_reg    <= '0;
      ram_wdata_reg   <= '0;
      cycle_count_reg <= '0;
      timeout_reg     <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum_reg         <= '0;
      error_reg       <= 1'b0;
`endif
    end else begin
      rom_idx_reg     <= rom_idx_next;
      ram_idx_reg     <= ram_idx_next;
      rom_we_reg      <= rom_we_next;
      rom_addr_reg    <= rom_addr_next;
      rom_wdata_reg   <= rom_wdata_next;
      ram_we_reg      <= ram_we_next;
      ram_addr_reg    <= ram_addr_next;
      ram_wdata_reg   <= ram_wdata_next;
      cycle_count_reg <= cycle_count_next;
      timeout_reg     <= timeout_next;
`ifdef BOOT_CHECKSUM_EN
      sum_reg         <= sum_next;
      error_reg       <= error_next;
`endif
    end
  end

  // Next-state and next-datapath logic; write strobes default to idle so
  // each accepted word produces exactly one write cycle.
  always_comb begin
    state_next       = state_reg;
    rom_idx_next     = rom_idx_reg;
    ram_idx_next     = ram_idx_reg;
    rom_we_next      = 1'b0;
    rom_addr_next    = '0;
    rom_wdata_next   = '0;
    ram_we_next      = 1'b0;
    ram_addr_next    = '0;
    ram_wdata_next   = '0;
    cycle_count_next = cycle_count_reg;
    timeout_next     = timeout_reg;
`ifdef BOOT_CHECKSUM_EN
    sum_next         = sum_reg;
    error_next       = error_reg;
`endif

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next       = S_LOAD_ROM;
          rom_idx_next     = '0;
          ram_idx_next     = '0;
          cycle_count_next = '0;
          timeout_next     = 1'b0;
`ifdef BOOT_CHECKSUM_EN
          sum_next         = '0;
          error_next       = 1'b0;
`endif
        end
      end

      S_LOAD_ROM: begin
        if (load_valid) begin
          rom_we_next    = 1'b1;
          rom_addr_next  = rom_idx_reg;
          rom_wdata_next = load_data;
`ifdef BOOT_CHECKSUM_EN
          sum_next       = sum_reg + load_data;
`endif
          if (rom_idx_reg == ROM_LAST) begin
            state_next = S_LOAD_RAM;
          end else begin
            rom_idx_next = rom_idx_reg + 1'b1;
          end
        end
      end

      S_LOAD_RAM: begin
        if (load_valid) begin
          ram_we_next    = 1'b1;
          ram_addr_next  = ram_idx_reg;
          ram_wdata_next = load_data[RAM_W-1:0];
`ifdef BOOT_CHECKSUM_EN
          sum_next       = sum_reg + load_data;
`endif
          if (ram_idx_reg == RAM_LAST) begin
`ifdef BOOT_CHECKSUM_EN
            state_next = S_CHECK;
`else
            state_next = S_RUN;
`endif
          end else begin
            ram_idx_next = ram_idx_reg + 1'b1;
          end
        end
      end

`ifdef BOOT_CHECKSUM_EN
      S_CHECK: begin
        if (load_valid) begin
          if (load_data == sum_reg) begin
            state_next = S_RUN;
          end else begin
            state_next = S_DONE;
            error_next = 1'b1;
          end
        end
      end
`endif

      S_RUN: begin
        cycle_count_next = cycle_count_inc;
        // A halt on the same edge as the limit wins over the timeout.
        if (cpu_halt) begin
          state_next   = S_DONE;
          timeout_next = 1'b0;
        end else if (cycle_count_inc >= RUN_LIMIT) begin
          state_next   = S_DONE;
          timeout_next = 1'b1;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Status outputs decoded from the state so reset clears them at once.
`ifdef BOOT_CHECKSUM_EN
  assign load_ready = (state_reg == S_LOAD_ROM) || (state_reg == S_LOAD_RAM) ||
                      (state_reg == S_CHECK);
  assign error      = error_reg;
`else
  assign load_ready = (state_reg == S_LOAD_ROM) || (state_reg == S_LOAD_RAM);
  assign error      = 1'b0;
`endif

  assign cpu_run     = (state_reg == S_RUN);
  assign done        = (state_reg == S_DONE);
  assign timeout     = timeout_reg;
  assign cycle_count = cycle_count_reg;

  assign rom_we      = rom_we_reg;
  assign rom_addr    = rom_addr_reg;
  assign rom_wdata   = rom_wdata_reg;
  assign ram_we      = ram_we_reg;
  assign ram_addr    = ram_addr_reg;
  assign ram_wdata   = ram_wdata_reg;

endmodule
